// File: rtl/audio_i2s_serializer.sv
// Final audio stage: captures one L/R sample pair per 48 kHz frame,
// applies mono mix / attenuation / mute, and serializes it as an I2S stream
// (mclk = clk/2, sclk = clk/4, lrck = clk/256, 32-bit slots, MSB first,
// one-bit data delay after each lrck edge).
module audio_i2s_serializer #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned ATTEN_WIDTH  = 3
) (
    input  logic                    clk_12_288_mhz,
    input  logic                    reset_n,
    input  logic [SAMPLE_WIDTH-1:0] sound_l,
    input  logic [SAMPLE_WIDTH-1:0] sound_r,
    input  logic                    mono,
    input  logic [ATTEN_WIDTH-1:0]  atten,
    input  logic                    mute,
    output logic                    audio_mclk,
    output logic                    audio_sclk,
    output logic                    audio_lrck,
    output logic                    audio_dac,
    output logic                    sample_tick
);

    localparam int unsigned CNT_WIDTH  = 8;
    localparam int unsigned SLOT_WIDTH = 6;
    localparam int unsigned BIT_WIDTH  = 5;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;

    logic [CNT_WIDTH-1:0]    cnt;
    logic [SAMPLE_WIDTH-1:0] word_l;
    logic [SAMPLE_WIDTH-1:0] word_r;

    logic                        capture_c;
    logic signed [SAMPLE_WIDTH:0]   mix_sum_c;
    logic signed [SAMPLE_WIDTH-1:0] mixed_l_c;
    logic signed [SAMPLE_WIDTH-1:0] mixed_r_c;
    logic signed [SAMPLE_WIDTH-1:0] scaled_l_c;
    logic signed [SAMPLE_WIDTH-1:0] scaled_r_c;
    logic [SAMPLE_WIDTH-1:0]     next_word_l_c;
    logic [SAMPLE_WIDTH-1:0]     next_word_r_c;

    logic [SLOT_WIDTH-1:0]   data_slot_c;
    logic [BIT_WIDTH-1:0]    bit_idx_c;
    logic [SAMPLE_WIDTH-1:0] word_sel_c;
    logic [SAMPLE_WIDTH-1:0] word_shift_c;
    logic                    dac_c;

    // Sample conditioning applied to the words latched at frame capture
    always_comb begin
        capture_c = (cnt == CNT_LAST);
        // 17-bit sum of two 16-bit signed samples cannot overflow; halve it back
        mix_sum_c = {sound_l[SAMPLE_WIDTH-1], sound_l} + {sound_r[SAMPLE_WIDTH-1], sound_r};
        mixed_l_c = sound_l;
        mixed_r_c = sound_r;
        if (mono) begin
            mixed_l_c = SAMPLE_WIDTH'(mix_sum_c >>> 1);
            mixed_r_c = SAMPLE_WIDTH'(mix_sum_c >>> 1);
        end
        scaled_l_c    = mixed_l_c >>> atten;
        scaled_r_c    = mixed_r_c >>> atten;
        next_word_l_c = mute ? '0 : scaled_l_c;
        next_word_r_c = mute ? '0 : scaled_r_c;
    end

    // Serial bit for the current counter value; slot index lags by one for the I2S delay bit
    always_comb begin
        data_slot_c  = cnt[CNT_WIDTH-1:2] - SLOT_WIDTH'(1);
        bit_idx_c    = data_slot_c[BIT_WIDTH-1:0];
        word_sel_c   = data_slot_c[SLOT_WIDTH-1] ? word_r : word_l;
        word_shift_c = word_sel_c << bit_idx_c;
        dac_c        = (32'(bit_idx_c) < SAMPLE_WIDTH) ? word_shift_c[SAMPLE_WIDTH-1] : 1'b0;
    end

    // Frame counter, per-frame word capture and registered I2S outputs
    always_ff @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            word_l      <= '0;
            word_r      <= '0;
            audio_mclk  <= 1'b0;
            audio_sclk  <= 1'b0;
            audio_lrck  <= 1'b0;
            audio_dac   <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            cnt         <= cnt + 1'b1;
            audio_mclk  <= cnt[0];
            audio_sclk  <= cnt[1];
            audio_lrck  <= cnt[CNT_WIDTH-1];
            audio_dac   <= dac_c;
            sample_tick <= capture_c;
            if (capture_c) begin
                word_l <= next_word_l_c;
                word_r <= next_word_r_c;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// Self-checking bench for audio_i2s_serializer: a per-cycle reference model
// plus literal frame expectations for the serial format and sample processing.
module tb_audio_i2s_serializer;

    logic        clk_12_288_mhz = 1'b0;
    logic        reset_n        = 1'b0;
    logic [15:0] sound_l        = 16'h0000;
    logic [15:0] sound_r        = 16'h0000;
    logic        mono           = 1'b0;
    logic [2:0]  atten          = 3'd0;
    logic        mute           = 1'b0;
    logic        audio_mclk;
    logic        audio_sclk;
    logic        audio_lrck;
    logic        audio_dac;
    logic        sample_tick;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_12_288_mhz = ~clk_12_288_mhz;

    audio_i2s_serializer dut (
        .clk_12_288_mhz (clk_12_288_mhz),
        .reset_n        (reset_n),
        .sound_l        (sound_l),
        .sound_r        (sound_r),
        .mono           (mono),
        .atten          (atten),
        .mute           (mute),
        .audio_mclk     (audio_mclk),
        .audio_sclk     (audio_sclk),
        .audio_lrck     (audio_lrck),
        .audio_dac      (audio_dac),
        .sample_tick    (sample_tick)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Floor division (rounds toward minus infinity), as an arithmetic shift does
    function automatic int fdiv(input int v, input int d);
        return (v >= 0) ? (v / d) : -((-v + d - 1) / d);
    endfunction

    // Word the DAC must carry for a channel, from plain integer arithmetic
    function automatic logic [15:0] proc(input logic [15:0] x, input logic [15:0] o,
                                         input logic m, input logic [2:0] a, input logic mu);
        int v;
        if (mu) return 16'h0000;
        v = m ? fdiv(int'($signed(x)) + int'($signed(o)), 2) : int'($signed(x));
        v = fdiv(v, 1 << a);
        return 16'(v);
    endfunction

    // Frame position c (0..255): slot 1..16 carries left MSB..LSB, 33..48 right
    function automatic logic exp_bit(input int c, input logic [15:0] wl, input logic [15:0] wr);
        int p;
        logic [15:0] t;
        p = c / 4;
        t = 16'h0000;
        if (p >= 1 && p <= 16)       t = wl << (p - 1);
        else if (p >= 33 && p <= 48) t = wr << (p - 33);
        return t[15];
    endfunction

    // Bits seen at the 64 sclk rising edges of one frame, first bit in the MSB
    function automatic logic [63:0] mk_frame(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'h0000, 1'b0, r, 15'h0000};
    endfunction

    // Reference model: position in frame and the words of the frame being sent
    int          m_cnt  = 0;
    logic [15:0] m_wl   = 16'h0000;
    logic [15:0] m_wr   = 16'h0000;
    logic        e_mclk = 1'b0;
    logic        e_sclk = 1'b0;
    logic        e_lrck = 1'b0;
    logic        e_dac  = 1'b0;
    logic        e_tick = 1'b0;

    always @(posedge clk_12_288_mhz or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt  <= 0;
            m_wl   <= 16'h0000;
            m_wr   <= 16'h0000;
            e_mclk <= 1'b0;
            e_sclk <= 1'b0;
            e_lrck <= 1'b0;
            e_dac  <= 1'b0;
            e_tick <= 1'b0;
        end else begin
            e_mclk <= (m_cnt % 2) == 1;
            e_sclk <= ((m_cnt / 2) % 2) == 1;
            e_lrck <= (m_cnt >= 128);
            e_dac  <= exp_bit(m_cnt, m_wl, m_wr);
            e_tick <= (m_cnt == 255);
            if (m_cnt == 255) begin
                m_wl <= proc(sound_l, sound_r, mono, atten, mute);
                m_wr <= proc(sound_r, sound_l, mono, atten, mute);
            end
            m_cnt <= (m_cnt + 1) % 256;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(posedge clk_12_288_mhz) begin
        #1;
        chk("mclk", 64'(audio_mclk), 64'(e_mclk));
        chk("sclk", 64'(audio_sclk), 64'(e_sclk));
        chk("lrck", 64'(audio_lrck), 64'(e_lrck));
        chk("dac",  64'(audio_dac),  64'(e_dac));
        chk("tick", 64'(sample_tick), 64'(e_tick));
    end

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_12_288_mhz);
            if (sample_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Wait for lrck to fall, then collect dac at the next 64 sclk rising edges
    task automatic grab_frame(output logic [63:0] bits, output bit ok);
        logic prev_lr;
        logic prev_sc;
        int   n;
        int   guard;
        bits    = 64'h0;
        ok      = 1'b0;
        prev_lr = audio_lrck;
        guard   = 0;
        while (guard < 600) begin
            @(negedge clk_12_288_mhz);
            guard++;
            if (prev_lr && !audio_lrck) break;
            prev_lr = audio_lrck;
        end
        if (guard >= 600) return;
        n       = 0;
        prev_sc = audio_sclk;
        while (n < 64 && guard < 1200) begin
            @(negedge clk_12_288_mhz);
            guard++;
            if (!prev_sc && audio_sclk) begin
                bits = {bits[62:0], audio_dac};
                n++;
            end
            prev_sc = audio_sclk;
        end
        ok = (n == 64);
    endtask

    task automatic run_frame(input string name, input logic [15:0] l, input logic [15:0] r,
                             input logic mo, input logic [2:0] at, input logic mu,
                             input logic [63:0] exp);
        bit ok;
        logic [63:0] bits;
        sound_l = l;
        sound_r = r;
        mono    = mo;
        atten   = at;
        mute    = mu;
        wait_tick(ok);
        if (!ok) begin
            timeout_fail({name, "_tick"});
            return;
        end
        grab_frame(bits, ok);
        if (!ok) timeout_fail({name, "_frame"});
        else     chk(name, bits, exp);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [63:0] bits;
        int          ticks;
        int          ones;

        // Model pinned against hand-computed words
        chk("model_mono_max",   64'(proc(16'h7FFF, 16'h7FFF, 1'b1, 3'd0, 1'b0)), 64'h7FFF);
        chk("model_mono_mixed", 64'(proc(16'h8000, 16'h7FFF, 1'b1, 3'd0, 1'b0)), 64'hFFFF);
        chk("model_atten1",     64'(proc(16'h8000, 16'h0000, 1'b0, 3'd1, 1'b0)), 64'hC000);
        chk("model_atten7",     64'(proc(16'h0100, 16'h0000, 1'b0, 3'd7, 1'b0)), 64'h0002);
        chk("model_atten3_neg", 64'(proc(16'hFFFF, 16'h0000, 1'b0, 3'd3, 1'b0)), 64'hFFFF);

        repeat (3) @(negedge clk_12_288_mhz);
        reset_n = 1'b1;

        run_frame("serial_format", 16'hA5C3, 16'h0001, 1'b0, 3'd0, 1'b0,
                  64'h52E1_8000_0000_8000);
        run_frame("mono_7fff_7fff", 16'h7FFF, 16'h7FFF, 1'b1, 3'd0, 1'b0,
                  mk_frame(16'h7FFF, 16'h7FFF));
        run_frame("mono_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'd0, 1'b0,
                  mk_frame(16'hFFFF, 16'hFFFF));
        run_frame("mono_8000_8000", 16'h8000, 16'h8000, 1'b1, 3'd0, 1'b0,
                  mk_frame(16'h8000, 16'h8000));
        run_frame("atten1_8000", 16'h8000, 16'h0000, 1'b0, 3'd1, 1'b0,
                  mk_frame(16'hC000, 16'h0000));
        run_frame("atten7_0100", 16'h0100, 16'h0000, 1'b0, 3'd7, 1'b0,
                  mk_frame(16'h0002, 16'h0000));
        run_frame("atten3_ffff", 16'hFFFF, 16'h0000, 1'b0, 3'd3, 1'b0,
                  mk_frame(16'hFFFF, 16'h0000));
        run_frame("mute", 16'hA5C3, 16'hFFFF, 1'b0, 3'd0, 1'b1, 64'h0);

        // Mid-frame input change must not disturb the frame on the wire
        sound_l = 16'h1234;
        sound_r = 16'h0000;
        atten   = 3'd0;
        mute    = 1'b0;
        wait_tick(ok);
        if (!ok) timeout_fail("isolation_tick");
        fork
            grab_frame(bits, ok);
            begin
                repeat (41) @(negedge clk_12_288_mhz);
                sound_l = 16'hABCD;
            end
        join
        if (!ok) timeout_fail("isolation_frame");
        else     chk("isolation_current", bits, mk_frame(16'h1234, 16'h0000));
        wait_tick(ok);
        if (!ok) timeout_fail("isolation_next_tick");
        grab_frame(bits, ok);
        if (!ok) timeout_fail("isolation_next_frame");
        else     chk("isolation_next", bits, mk_frame(16'hABCD, 16'h0000));

        // One capture pulse per 256 clocks
        ticks = 0;
        repeat (512) begin
            @(negedge clk_12_288_mhz);
            if (sample_tick) ticks++;
        end
        chk("tick_count_512", 64'(ticks), 64'd2);

        // Reset mid-frame with live data
        sound_l = 16'hA5C3;
        sound_r = 16'h5A5A;
        repeat (300) @(negedge clk_12_288_mhz);
        repeat (70) @(negedge clk_12_288_mhz);
        reset_n = 1'b0;
        #1;
        chk("reset_outputs_async",
            64'({audio_mclk, audio_sclk, audio_lrck, audio_dac, sample_tick}), 64'd0);
        repeat (3) @(negedge clk_12_288_mhz);
        chk("reset_outputs_held",
            64'({audio_mclk, audio_sclk, audio_lrck, audio_dac, sample_tick}), 64'd0);
        reset_n = 1'b1;

        // First frame after release carries the reset (zero) words
        ones = 0;
        repeat (256) begin
            @(negedge clk_12_288_mhz);
            if (audio_dac) ones++;
        end
        chk("first_frame_zero", 64'(ones), 64'd0);
        grab_frame(bits, ok);
        if (!ok) timeout_fail("first_real_frame");
        else     chk("first_real_frame", bits, mk_frame(16'hA5C3, 16'h5A5A));

        repeat (4) @(negedge clk_12_288_mhz);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
